// File: rtl/galaga_lib.sv
// -----------------------------------------------------------------------------
// galaga_lib
// Shared constants and types for the ship/enemy projectile logic.
//   NP_DEFAULT        default size of a projectile slot pool
//   FIRE_KEY_DEFAULT  keyboard usage code of the fire key (space bar)
//   alloc_mode_t      slot allocation policy (fixed priority / round-robin)
//   fire_state_t      fire-rate limiter state (ready to fire / cooling down)
// -----------------------------------------------------------------------------
package galaga_lib;

    localparam int         NP_DEFAULT       = 10;
    localparam logic [7:0] FIRE_KEY_DEFAULT = 8'h2C;

    typedef enum logic {
        ALLOC_PRIO = 1'b0,
        ALLOC_RR   = 1'b1
    } alloc_mode_t;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_COOL  = 1'b1
    } fire_state_t;

endpackage

// File: rtl/proj_slot_picker.sv
// -----------------------------------------------------------------------------
// proj_slot_picker
// Purely combinational free-slot finder for a projectile pool.
//   busy_i   1 = slot occupied (in flight or reserved)
//   start_i  first index examined in round-robin mode
//   mode_i   ALLOC_PRIO: scan from index 0; ALLOC_RR: scan from start_i, wrapping
//   found_o  a free slot exists
//   idx_o    index of the first free slot in scan order (0 when none found)
// -----------------------------------------------------------------------------
module proj_slot_picker
    import galaga_lib::*;
#(
    parameter  int NP    = NP_DEFAULT,
    localparam int IDX_W = $clog2(NP)
) (
    input  logic [NP-1:0]    busy_i,
    input  logic [IDX_W-1:0] start_i,
    input  alloc_mode_t      mode_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] base_s;
    logic [IDX_W:0]   cand_s;

    // Scan the pool starting at base; walking offsets high-to-low lets the
    // smallest offset (first in scan order) win the final assignment.
    always_comb begin
        base_s  = (mode_i == ALLOC_RR) ? start_i : '0;
        found_o = 1'b0;
        idx_o   = '0;
        cand_s  = '0;
        for (int j = NP - 1; j >= 0; j--) begin
            cand_s = {1'b0, base_s} + (IDX_W+1)'(j);
            // Wrap the rotated index back into 0..NP-1.
            if (cand_s >= (IDX_W+1)'(NP)) begin
                cand_s = cand_s - (IDX_W+1)'(NP);
            end else begin
                cand_s = cand_s;
            end
            if (!busy_i[cand_s[IDX_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand_s[IDX_W-1:0];
            end else begin
                found_o = found_o;
                idx_o   = idx_o;
            end
        end
    end

endmodule

// File: rtl/ship_projectile_allocator.sv
// -----------------------------------------------------------------------------
// ship_projectile_allocator
// Watches the keyboard report for the fire key and launches a free slot of the
// ship's projectile pool, once per frame at most.
//   frame_clk   frame-rate clock
//   Reset       synchronous, active-high reset
//   keycode     keyboard report, NKEY bytes
//   auto_mode   0 = one shot per press, 1 = repeat while held
//   rr_mode     0 = lowest free slot, 1 = round-robin after last fired slot
//   ProjEn      slot currently in flight
//   ProjActvt   one-hot, one-frame activation pulse
//   fire_pulse  high in the frame ProjActvt is non-zero
//   fire_idx    index of the last slot fired
//   live_count  number of busy slots (in flight or reserved)
//   dropped     one-frame pulse when a shot was wanted but no slot / cap reached
// -----------------------------------------------------------------------------
module ship_projectile_allocator
    import galaga_lib::*;
#(
    parameter  int         NP       = NP_DEFAULT,
    parameter  int         NKEY     = 2,
    parameter  logic [7:0] FIRE_KEY = FIRE_KEY_DEFAULT,
    parameter  int         COOLDOWN = 4,
    parameter  int         MAX_LIVE = NP,
    localparam int         IDX_W    = $clog2(NP),
    localparam int         CNT_W    = $clog2(NP + 1)
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic [8*NKEY-1:0] keycode,
    input  logic              auto_mode,
    input  logic              rr_mode,
    input  logic [NP-1:0]     ProjEn,
    output logic [NP-1:0]     ProjActvt,
    output logic              fire_pulse,
    output logic [IDX_W-1:0]  fire_idx,
    output logic [CNT_W-1:0]  live_count,
    output logic              dropped
);

    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    fire_state_t      state_q, state_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    logic             pressed_prev_q;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [NP-1:0]    actvt_q, actvt_d;
    logic             fire_pulse_q, fire_pulse_d;
    logic [IDX_W-1:0] fire_idx_q, fire_idx_d;
    logic [CNT_W-1:0] live_q;
    logic             dropped_q, dropped_d;

    logic             pressed_s;
    logic             req_s;
    logic [NP-1:0]    busy_s;
    logic [CNT_W-1:0] live_s;
    logic [IDX_W-1:0] start_s;
    logic             found_s;
    logic [IDX_W-1:0] sel_s;
    logic             fire_s;
    logic             drop_s;

    // Fire key detection, request qualification, busy vector and popcount.
    // The previous frame's activation is counted busy until ProjEn catches up.
    always_comb begin
        pressed_s = 1'b0;
        for (int k = 0; k < NKEY; k++) begin
            pressed_s = pressed_s | (keycode[8*k +: 8] == FIRE_KEY);
        end
        req_s  = (auto_mode ? pressed_s : (pressed_s & ~pressed_prev_q))
                 & (state_q == ST_READY);
        busy_s = ProjEn | actvt_q;
        live_s = '0;
        for (int i = 0; i < NP; i++) begin
            live_s = live_s + CNT_W'(busy_s[i]);
        end
        start_s = (rr_ptr_q == IDX_W'(NP - 1)) ? '0 : rr_ptr_q + IDX_W'(1);
        fire_s  = req_s & found_s & (live_s < CNT_W'(MAX_LIVE));
        drop_s  = req_s & ~fire_s;
    end

    proj_slot_picker #(
        .NP (NP)
    ) u_picker (
        .busy_i  (busy_s),
        .start_i (start_s),
        .mode_i  (alloc_mode_t'(rr_mode)),
        .found_o (found_s),
        .idx_o   (sel_s)
    );

    // Next values of the shot outputs, allocation pointer and cooldown FSM.
    always_comb begin
        actvt_d      = fire_s ? (NP'(1) << sel_s) : '0;
        fire_pulse_d = fire_s;
        fire_idx_d   = fire_s ? sel_s : fire_idx_q;
        rr_ptr_d     = fire_s ? sel_s : rr_ptr_q;
        dropped_d    = drop_s;
        state_d      = state_q;
        if (fire_s) begin
            cd_d = CD_W'(COOLDOWN);
        end else if (cd_q != '0) begin
            cd_d = cd_q - CD_W'(1);
        end else begin
            cd_d = '0;
        end
        case (state_q)
            ST_READY: begin
                if (fire_s && (COOLDOWN > 0)) begin
                    state_d = ST_COOL;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_COOL: begin
                if (cd_d == '0) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_COOL;
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    // State and output registers; the fire key reads as held out of reset.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q        <= ST_READY;
            cd_q           <= '0;
            pressed_prev_q <= 1'b1;
            rr_ptr_q       <= IDX_W'(NP - 1);
            actvt_q        <= '0;
            fire_pulse_q   <= 1'b0;
            fire_idx_q     <= '0;
            live_q         <= '0;
            dropped_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cd_q           <= cd_d;
            pressed_prev_q <= pressed_s;
            rr_ptr_q       <= rr_ptr_d;
            actvt_q        <= actvt_d;
            fire_pulse_q   <= fire_pulse_d;
            fire_idx_q     <= fire_idx_d;
            live_q         <= live_s;
            dropped_q      <= dropped_d;
        end
    end

    assign ProjActvt  = actvt_q;
    assign fire_pulse = fire_pulse_q;
    assign fire_idx   = fire_idx_q;
    assign live_count = live_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_ship_projectile_allocator.sv
// -----------------------------------------------------------------------------
// tb_ship_projectile_allocator
// Two allocators (NP=4) share one stimulus stream:
//   A: COOLDOWN=3, MAX_LIVE=3      B: COOLDOWN=0, MAX_LIVE=4
// -----------------------------------------------------------------------------
module tb_ship_projectile_allocator;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [15:0] keycode;
    logic        auto_mode;
    logic        rr_mode;
    logic [3:0]  ProjEn;

    logic [3:0]  a_act, b_act;
    logic        a_pulse, b_pulse;
    logic [1:0]  a_idx, b_idx;
    logic [2:0]  a_live, b_live;
    logic        a_drop, b_drop;

    int vectors = 0;
    int fails   = 0;
    bit chk_en  = 1'b0;
    bit mirror  = 1'b0;

    // Reference state per instance (index 0 = A, 1 = B).
    int       cdp[2] = '{3, 0};
    int       mlp[2] = '{3, 4};
    bit       m_pp[2];
    int       m_cd[2];
    bit [3:0] m_res[2];
    int       m_last[2];
    bit [3:0] e_act[2];
    bit       e_pulse[2];
    int       e_idx[2];
    int       e_live[2];
    bit       e_drop[2];

    always #5 frame_clk = ~frame_clk;

    ship_projectile_allocator #(
        .NP(4), .NKEY(2), .FIRE_KEY(8'h2C), .COOLDOWN(3), .MAX_LIVE(3)
    ) dut_a (
        .frame_clk (frame_clk), .Reset (Reset), .keycode (keycode),
        .auto_mode (auto_mode), .rr_mode (rr_mode), .ProjEn (ProjEn),
        .ProjActvt (a_act), .fire_pulse (a_pulse), .fire_idx (a_idx),
        .live_count (a_live), .dropped (a_drop)
    );

    ship_projectile_allocator #(
        .NP(4), .NKEY(2), .FIRE_KEY(8'h2C), .COOLDOWN(0), .MAX_LIVE(4)
    ) dut_b (
        .frame_clk (frame_clk), .Reset (Reset), .keycode (keycode),
        .auto_mode (auto_mode), .rr_mode (rr_mode), .ProjEn (ProjEn),
        .ProjActvt (b_act), .fire_pulse (b_pulse), .fire_idx (b_idx),
        .live_count (b_live), .dropped (b_drop)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: one frame of the allocator rules for each instance.
    always @(posedge frame_clk) begin
        bit       pressed, req, found;
        bit [3:0] busy;
        int       live, sel, i;
        pressed = (keycode[7:0] == 8'h2C) || (keycode[15:8] == 8'h2C);
        for (int n = 0; n < 2; n++) begin
            if (Reset) begin
                m_pp[n] = 1'b1; m_cd[n] = 0; m_res[n] = 4'b0; m_last[n] = 3;
                e_act[n] = 4'b0; e_pulse[n] = 1'b0; e_idx[n] = 0;
                e_live[n] = 0; e_drop[n] = 1'b0;
            end else begin
                req   = auto_mode ? pressed : (pressed && !m_pp[n]);
                busy  = ProjEn | m_res[n];
                live  = $countones(busy);
                found = 1'b0;
                sel   = 0;
                for (int j = 0; j < 4; j++) begin
                    i = rr_mode ? (m_last[n] + 1 + j) % 4 : j;
                    if (!found && !busy[i]) begin
                        found = 1'b1;
                        sel   = i;
                    end
                end
                e_act[n]   = 4'b0;
                e_pulse[n] = 1'b0;
                e_drop[n]  = 1'b0;
                if (req && m_cd[n] == 0 && found && live < mlp[n]) begin
                    e_act[n]   = 4'b0001 << sel;
                    e_pulse[n] = 1'b1;
                    e_idx[n]   = sel;
                    m_last[n]  = sel;
                    m_cd[n]    = cdp[n];
                end else begin
                    if (req && m_cd[n] == 0) e_drop[n] = 1'b1;
                    if (m_cd[n] > 0) m_cd[n] = m_cd[n] - 1;
                end
                e_live[n] = live;
                m_res[n]  = e_act[n];
                m_pp[n]   = pressed;
            end
        end
    end

    // Every-frame comparison of both instances against the reference.
    always @(negedge frame_clk) begin
        if (chk_en) begin
            cmp("A.ProjActvt",  32'(a_act),   32'(e_act[0]));
            cmp("A.fire_pulse", 32'(a_pulse), 32'(e_pulse[0]));
            cmp("A.fire_idx",   32'(a_idx),   32'(e_idx[0]));
            cmp("A.live_count", 32'(a_live),  32'(e_live[0]));
            cmp("A.dropped",    32'(a_drop),  32'(e_drop[0]));
            cmp("B.ProjActvt",  32'(b_act),   32'(e_act[1]));
            cmp("B.fire_pulse", 32'(b_pulse), 32'(e_pulse[1]));
            cmp("B.fire_idx",   32'(b_idx),   32'(e_idx[1]));
            cmp("B.live_count", 32'(b_live),  32'(e_live[1]));
            cmp("B.dropped",    32'(b_drop),  32'(e_drop[1]));
        end
    end

    // Advance one frame; optionally let ProjEn latch A's launched slot.
    task automatic tick();
        @(posedge frame_clk);
        #2;
        if (mirror) ProjEn = ProjEn | e_act[0];
    endtask

    initial begin
        Reset = 1'b1; keycode = 16'h0000; auto_mode = 1'b0; rr_mode = 1'b0; ProjEn = 4'b0000;
        tick();
        chk_en = 1'b1;
        tick();
        cmp("reset_actvt", 32'(a_act), 32'd0);
        cmp("reset_live",  32'(a_live), 32'd0);
        cmp("reset_idx",   32'(a_idx), 32'd0);
        Reset = 1'b0;
        tick();

        // Semi-auto, priority: one shot per press.
        mirror = 1'b1; keycode = 16'h002C;
        tick();
        cmp("semi_first_shot", 32'(a_act), 32'h1);
        cmp("semi_first_idx",  32'(a_idx), 32'd0);
        tick();
        cmp("semi_no_repeat",  32'(a_act), 32'h0);
        cmp("semi_live_one",   32'(a_live), 32'd1);
        repeat (3) tick();
        keycode = 16'h0000;
        tick();
        keycode = 16'h002C;
        tick();
        cmp("semi_second_shot", 32'(a_act), 32'h2);
        cmp("semi_second_idx",  32'(a_idx), 32'd1);
        keycode = 16'h0000;

        // Full-auto with cooldown 3: shots on frames 1, 5, 9.
        ProjEn = 4'b0000;
        repeat (4) tick();
        auto_mode = 1'b1; keycode = 16'h002C;
        for (int s = 1; s <= 12; s++) begin
            tick();
            cmp("auto_pulse_pattern", 32'(a_pulse), ((s % 4) == 1) ? 32'd1 : 32'd0);
            if ((s % 4) == 1) cmp("auto_idx", 32'(a_idx), 32'((s - 1) / 4));
        end
        keycode = 16'h0000; auto_mode = 1'b0;

        // Round-robin after slot 2, wrap, then rotate past slot 0.
        ProjEn = 4'b0000;
        repeat (4) tick();
        rr_mode = 1'b1; keycode = 16'h002C;
        tick();
        cmp("rr_after_2", 32'(a_act), 32'h8);
        keycode = 16'h0000;
        repeat (3) tick();
        keycode = 16'h002C;
        tick();
        cmp("rr_wrap", 32'(a_act), 32'h1);
        keycode = 16'h0000; ProjEn = 4'b0000;
        repeat (3) tick();
        keycode = 16'h002C;
        tick();
        cmp("rr_after_0", 32'(a_act), 32'h2);
        keycode = 16'h0000;
        tick();
        keycode = 16'h002C;
        tick();
        cmp("cool_silent_act",  32'(a_act), 32'h0);
        cmp("cool_silent_drop", 32'(a_drop), 32'd0);
        keycode = 16'h0000; rr_mode = 1'b0;

        // Live cap and no-free-slot drops.
        mirror = 1'b0; ProjEn = 4'b0111;
        repeat (3) tick();
        keycode = 16'h002C;
        tick();
        cmp("cap_drop",     32'(a_drop), 32'd1);
        cmp("cap_no_shot",  32'(a_act), 32'h0);
        cmp("B_below_cap",  32'(b_act), 32'h8);
        tick();
        cmp("cap_drop_one_frame", 32'(a_drop), 32'd0);
        auto_mode = 1'b1;
        tick();
        cmp("auto_retry_drop1", 32'(a_drop), 32'd1);
        tick();
        cmp("auto_retry_drop2", 32'(a_drop), 32'd1);
        ProjEn = 4'b0110;
        tick();
        cmp("cap_released_shot", 32'(a_act), 32'h1);
        ProjEn = 4'b1111;
        tick();
        cmp("B_full_drop",        32'(b_drop), 32'd1);
        cmp("A_cool_no_drop",     32'(a_drop), 32'd0);
        keycode = 16'h0000; auto_mode = 1'b0; ProjEn = 4'b0000;

        // Fire key in either report byte.
        repeat (4) tick();
        keycode = 16'h2C00;
        tick();
        cmp("upper_byte_fire", 32'(a_act), 32'h1);
        keycode = 16'h0000;
        repeat (4) tick();
        keycode = 16'h2B2B;
        tick();
        cmp("other_key_act",  32'(a_act), 32'h0);
        cmp("other_key_drop", 32'(a_drop), 32'd0);
        tick();

        // Key held across reset.
        keycode = 16'h002C;
        tick();
        cmp("pre_reset_shot", 32'(a_pulse), 32'd1);
        Reset = 1'b1;
        tick();
        cmp("reset_clr_act",   32'(a_act), 32'h0);
        cmp("reset_clr_pulse", 32'(a_pulse), 32'd0);
        cmp("reset_clr_live",  32'(a_live), 32'd0);
        Reset = 1'b0;
        tick();
        cmp("held_after_reset1", 32'(a_act), 32'h0);
        tick();
        cmp("held_after_reset2", 32'(a_act), 32'h0);
        keycode = 16'h0000;
        tick();
        keycode = 16'h002C;
        tick();
        cmp("repress_after_reset", 32'(a_act), 32'h1);

        // Reset during cooldown, auto fires on the first frame after.
        auto_mode = 1'b1;
        tick();
        Reset = 1'b1;
        tick();
        cmp("reset_in_cool_live", 32'(a_live), 32'd0);
        Reset = 1'b0;
        tick();
        cmp("auto_after_reset_act", 32'(a_act), 32'h1);
        cmp("auto_after_reset_idx", 32'(a_idx), 32'd0);
        keycode = 16'h0000; auto_mode = 1'b0;
        repeat (2) tick();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
